sr_stack: RTL and testbench
===========================

Name: sr_stack

Overview:
- Hardware LIFO stack that backs the PUSH/POP instructions of the single-cycle sr_cpu.
- Sits between the decode/writeback path and the register file.
- PUSH: stores rs2 data on the stack. POP: returns the top of stack to rd in the same cycle.
- Provides status flags and sticky error flags so the testbench and debug logic can detect stack misuse.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); the stack pointer is ADDR_W+1 bits wide.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of the stack and error flags.
- push  input  1  push request for this cycle.
- pop  input  1  pop request for this cycle.
- pushData  input  WIDTH  word to push (CPU rs2 read data).
- popData  output  WIDTH  current top-of-stack word, combinational.
- count  output  ADDR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Storage and pointer:
  - Storage is DEPTH x WIDTH registers.
  - sp is ADDR_W+1 bits, points to the next free slot, and count = sp.
  - Memory contents are not reset.
- Reset (rst high, asynchronous, any time including mid-operation):
  - sp=0, overflow=0, underflow=0.
  - Resulting outputs: count=0, empty=1, full=0, popData=0.
- popData is combinational, zero read latency:
  - mem[sp-1] when !empty, else 0.
  - The CPU samples it in the same cycle it asserts pop.
- Priority per rising edge: clear > push/pop.
- clear: sp<=0, overflow<=0, underflow<=0. Any push or pop in the same cycle is ignored.
- push only:
  - !full: mem[sp]<=pushData, sp<=sp+1.
  - full: no write, sp unchanged, overflow<=1.
- pop only:
  - !empty: sp<=sp-1.
  - empty: sp unchanged, underflow<=1, popData=0.
- push and pop in the same cycle:
  - !empty: popData returns the old top. mem[sp-1]<=pushData (top replaced), sp unchanged. No overflow even if full.
  - empty: underflow<=1, popData=0, then the push executes normally (mem[0]<=pushData, sp<=1).
- Sticky flags: overflow and underflow stay set until clear or rst. They never block subsequent legal operations.
- Arithmetic and boundaries:
  - sp never wraps; it saturates in behaviour at 0 and DEPTH via the rules above.
  - Index arithmetic uses the low ADDR_W bits of sp and sp-1 only when in range.
- No handshake stalls: every request completes in one cycle. The CPU must not rely on back-pressure.
- empty, full and count are registered-state derived and glitch-free after the clock edge.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-cycle after 3 pushes.
  - Required: count=0, empty=1 immediately (asynchronous), popData=0, flags 0.
  - After release: push 0xA5A5A5A5 gives count=1, popData=0xA5A5A5A5.
- LIFO order:
  - Stimulus: push 1,2,3, then pop three times.
  - Required: popData reads 3,2,1 in the pop cycles; count goes 3->2->1->0; empty=1 at the end.
- Full/overflow:
  - Stimulus: push 0..15 (DEPTH=16), then push 0xDEAD.
  - Required: full=1, count=16, popData=15, overflow=1, top still 15.
  - Then pop: count=15, popData=14, overflow remains 1.
- Underflow:
  - Stimulus: pop while empty.
  - Required: popData=0, count=0, underflow=1.
  - Then push 7: count=1, popData=7, underflow still 1.
- Simultaneous push and pop:
  - Stimulus: with stack [5,9] (9 on top), assert push=1 with pushData=42 and pop=1.
  - Required: in that cycle popData=9; after the edge count=2, popData=42.
  - Repeat on an empty stack with pushData=8: underflow=1, then count=1, popData=8.
- Clear priority:
  - Stimulus: with count=4 and overflow=1, assert clear together with push=1.
  - Required: after the edge count=0, empty=1, overflow=0, underflow=0, no entry written.

Source files
------------

// File: rtl/sr_stack.sv
// sr_stack: single-cycle LIFO stack behind the sr_cpu PUSH/POP instructions.
//
// Ports:
//   clk        core clock; all state updates on its rising edge
//   rst        asynchronous, active-high reset (clears pointer and error flags)
//   clear      synchronous flush of pointer and error flags; beats push/pop
//   push       push request; pushData is stored on top
//   pop        pop request; popData is the word being popped this cycle
//   pushData   word to push (CPU rs2 read data)
//   popData    current top-of-stack word, combinational; 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was attempted while full
//   underflow  sticky: a pop was attempted while empty
module sr_stack #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  pushData,
    output logic [WIDTH-1:0]  popData,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned SP_W = ADDR_W + 1;

    // Storage, stack pointer (next free slot) and sticky error flags
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;

    // Write port control produced by the next-state logic
    logic              we_c;
    logic [ADDR_W-1:0] widx_c;

    // Status decode straight from the registered pointer
    logic              empty_c;
    logic              full_c;
    logic [ADDR_W-1:0] top_idx_c;

    assign empty_c   = (sp_q == '0);
    assign full_c    = (sp_q == SP_W'(DEPTH));
    // Only meaningful when !empty; low bits of sp-1 address the top entry
    assign top_idx_c = ADDR_W'(sp_q - SP_W'(1));

    assign count     = sp_q;
    assign empty     = empty_c;
    assign full      = full_c;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign popData   = empty_c ? '0 : mem_q[top_idx_c];

    // Next-state and write-port decode; clear overrides any request
    always_comb begin
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        we_c   = 1'b0;
        widx_c = ADDR_W'(sp_q);

        if (clear) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (full_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        we_c   = 1'b1;
                        widx_c = ADDR_W'(sp_q);
                        sp_d   = sp_q + SP_W'(1);
                    end
                end
                2'b01: begin
                    if (empty_c) begin
                        unf_d = 1'b1;
                    end else begin
                        sp_d = sp_q - SP_W'(1);
                    end
                end
                2'b11: begin
                    // Non-empty: replace the top in place, so full never overflows.
                    // Empty: the pop underflows, then the push proceeds normally.
                    if (empty_c) begin
                        unf_d  = 1'b1;
                        we_c   = 1'b1;
                        widx_c = '0;
                        sp_d   = SP_W'(1);
                    end else begin
                        we_c   = 1'b1;
                        widx_c = top_idx_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[widx_c] <= pushData;
        end
    end

endmodule

// File: tb/tb_sr_stack.sv
module tb_sr_stack;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  pushData;
    logic [WIDTH-1:0]  popData;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int checks;
    int errors;

    sr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .pushData  (pushData),
        .popData   (popData),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] v);
        push     = 1'b1;
        pushData = v;
        step();
        push     = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        pushData = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pop", popData, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);

        // Asynchronous reset mid-cycle after three pushes
        do_push(32'h11);
        do_push(32'h22);
        do_push(32'h33);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_top", popData, 32'h33);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_pop", popData, 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_unf", 32'(underflow), 32'd0);
        #2 rst = 1'b0;
        step();
        do_push(32'hA5A5A5A5);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_top", popData, 32'hA5A5A5A5);
        do_pop();
        check("post_rst_empty", 32'(empty), 32'd1);

        // LIFO order
        do_push(32'd1);
        do_push(32'd2);
        do_push(32'd3);
        check("lifo_count3", 32'(count), 32'd3);
        for (int i = 3; i >= 1; i--) begin
            pop = 1'b1;
            #1;
            check("lifo_pop_data", popData, 32'(i));
            step();
            pop = 1'b0;
            check("lifo_count", 32'(count), 32'(i - 1));
        end
        check("lifo_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 16; i++) do_push(32'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);
        check("full_top", popData, 32'd15);
        check("full_ovf_pre", 32'(overflow), 32'd0);
        do_push(32'hDEAD);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_top", popData, 32'd15);
        do_pop();
        check("ovf_pop_count", 32'(count), 32'd15);
        check("ovf_pop_top", popData, 32'd14);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_not_full", 32'(full), 32'd0);
        do_clear();
        check("clr1_count", 32'(count), 32'd0);
        check("clr1_ovf", 32'(overflow), 32'd0);

        // Underflow
        pop = 1'b1;
        #1;
        check("unf_pop_data", popData, 32'd0);
        step();
        pop = 1'b0;
        check("unf_count", 32'(count), 32'd0);
        check("unf_flag", 32'(underflow), 32'd1);
        do_push(32'd7);
        check("unf_push_count", 32'(count), 32'd1);
        check("unf_push_top", popData, 32'd7);
        check("unf_sticky", 32'(underflow), 32'd1);
        do_clear();
        check("clr2_unf", 32'(underflow), 32'd0);

        // Simultaneous push+pop on non-empty stack [5,9]
        do_push(32'd5);
        do_push(32'd9);
        push     = 1'b1;
        pop      = 1'b1;
        pushData = 32'd42;
        #1;
        check("pp_old_top", popData, 32'd9);
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("pp_count", 32'(count), 32'd2);
        check("pp_new_top", popData, 32'd42);
        check("pp_unf", 32'(underflow), 32'd0);
        do_pop();
        check("pp_below", popData, 32'd5);
        do_clear();

        // Simultaneous push+pop on empty stack
        push     = 1'b1;
        pop      = 1'b1;
        pushData = 32'd8;
        #1;
        check("ppe_pop_data", popData, 32'd0);
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("ppe_unf", 32'(underflow), 32'd1);
        check("ppe_count", 32'(count), 32'd1);
        check("ppe_top", popData, 32'd8);
        do_clear();

        // Simultaneous push+pop while full: top replaced, no overflow
        for (int i = 0; i < 16; i++) do_push(32'h100 + 32'(i));
        push     = 1'b1;
        pop      = 1'b1;
        pushData = 32'h77;
        #1;
        check("ppf_old_top", popData, 32'h10F);
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("ppf_ovf", 32'(overflow), 32'd0);
        check("ppf_count", 32'(count), 32'd16);
        check("ppf_top", popData, 32'h77);

        // Build count=4 with overflow set, then clear together with push
        do_push(32'hBAD);
        check("cp_ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 12; i++) do_pop();
        check("cp_count4", 32'(count), 32'd4);
        check("cp_top4", popData, 32'h103);
        clear    = 1'b1;
        push     = 1'b1;
        pushData = 32'hEEEE;
        step();
        clear = 1'b0;
        push  = 1'b0;
        check("cp_count", 32'(count), 32'd0);
        check("cp_empty", 32'(empty), 32'd1);
        check("cp_ovf", 32'(overflow), 32'd0);
        check("cp_unf", 32'(underflow), 32'd0);
        check("cp_pop", popData, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
